// File: rtl/alu_m_unit.sv
// Integer execution unit: RV32I ALU ops plus RV32M multiply/divide, results tagged for ROB write-back.
// Latency: base ops and divide special cases take 1 cycle, MUL* take MUL_LATENCY, a normal DIV/REM takes XLEN+1.
// Backpressure: busy_out is high while a multi-cycle op is in flight, and valid_in is ignored then; rdy_in low freezes the unit.
module alu_m_unit #(
   parameter int XLEN        = 32,
   parameter int TAG_WIDTH   = 5,
   parameter int MUL_LATENCY = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 rdy_in,
   input  logic                 need_flush_in,
   input  logic                 valid_in,
   input  logic [XLEN-1:0]      opr1_in,
   input  logic [XLEN-1:0]      opr2_in,
   input  logic [TAG_WIDTH-1:0] rob_id_in,
   input  logic [2:0]           op_L1_in,
   input  logic                 op_L2_in,
   input  logic                 is_m_in,
   input  logic                 is_I_type_in,
   output logic                 busy_out,
   output logic [XLEN-1:0]      value_out,
   output logic [TAG_WIDTH-1:0] rob_id_out,
   output logic                 ready_out
);
   localparam int SHW     = $clog2(XLEN);
   localparam int CNT_MAX = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN);
   localparam logic [CW-1:0]   MUL_LAST = CW'(MUL_LATENCY - 1);
   localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic                 pend;      // single-cycle result due on the next enabled edge
   logic                 m_q;       // pending result is a divide special case
   logic                 sub_q, sra_q, dneg_q, rneg_q;
   logic [2:0]           f3_q;
   logic [XLEN-1:0]      a_q;       // operand 1; quotient shift register while dividing
   logic [XLEN-1:0]      b_q;       // operand 2; divisor magnitude while dividing
   logic [XLEN-1:0]      rem_q;
   logic [TAG_WIDTH-1:0] tag_q;

   logic [XLEN-1:0]          alu_res, spec_res, pend_res, mul_res, div_res;
   logic [XLEN-1:0]          rem_nxt, quo_nxt, mag1, mag2;
   logic signed [XLEN-1:0]   sra_v;
   logic signed [2*XLEN-1:0] mul_a, mul_b, prod;
   logic [XLEN:0]            shifted;
   logic                     ge, in_signed, in_special;

   assign busy_out = (state != S_IDLE);

   // Single-cycle ALU and divide special-case results from the latched operands
   always_comb begin
      sra_v = $signed(a_q) >>> b_q[SHW-1:0];
      alu_res = '0;
      case (f3_q)
         3'b000:  alu_res = sub_q ? (a_q - b_q) : (a_q + b_q);
         3'b001:  alu_res = a_q << b_q[SHW-1:0];
         3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         3'b011:  alu_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
         3'b100:  alu_res = a_q ^ b_q;
         3'b101:  alu_res = sra_q ? sra_v : (a_q >> b_q[SHW-1:0]);
         3'b110:  alu_res = a_q | b_q;
         default: alu_res = a_q & b_q;
      endcase
      // only zero divisor and signed overflow ever reach here
      if (b_q == '0) spec_res = f3_q[1] ? a_q : '1;
      else           spec_res = f3_q[1] ? '0  : a_q;
      pend_res = m_q ? spec_res : alu_res;
   end

   // Multiplier on sign- or zero-extended operands, plus one restoring-divide step and sign fix
   always_comb begin
      mul_a = (f3_q != 3'b011)      ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
      mul_b = (f3_q[1:0] == 2'b01)  ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
      prod  = mul_a * mul_b;
      mul_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      shifted = {rem_q, a_q[XLEN-1]};
      ge      = (shifted >= {1'b0, b_q});
      rem_nxt = ge ? (shifted[XLEN-1:0] - b_q) : shifted[XLEN-1:0];
      quo_nxt = {a_q[XLEN-2:0], ge};
      div_res = f3_q[1] ? (rneg_q ? -rem_q : rem_q) : (dneg_q ? -a_q : a_q);
   end

   // Issue-side decode: operand magnitudes and divide early-out detection
   always_comb begin
      in_signed  = ~op_L1_in[0];
      mag1       = (in_signed && opr1_in[XLEN-1]) ? -opr1_in : opr1_in;
      mag2       = (in_signed && opr2_in[XLEN-1]) ? -opr2_in : opr2_in;
      in_special = (opr2_in == '0) || (in_signed && (opr1_in == SMIN) && (&opr2_in));
   end

   // Control FSM, operand latches and registered result outputs
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state      <= S_IDLE;
         cnt        <= '0;
         pend       <= 1'b0;
         m_q        <= 1'b0;
         sub_q      <= 1'b0;
         sra_q      <= 1'b0;
         dneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
         f3_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rem_q      <= '0;
         tag_q      <= '0;
         value_out  <= '0;
         rob_id_out <= '0;
         ready_out  <= 1'b0;
      end else if (!rdy_in) begin
         ready_out <= 1'b0;
      end else if (need_flush_in) begin
         state     <= S_IDLE;
         cnt       <= '0;
         pend      <= 1'b0;
         ready_out <= 1'b0;
      end else begin
         ready_out <= 1'b0;
         pend      <= 1'b0;
         if (pend) begin
            value_out  <= pend_res;
            rob_id_out <= tag_q;
            ready_out  <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (valid_in) begin
                  a_q   <= opr1_in;
                  b_q   <= opr2_in;
                  f3_q  <= op_L1_in;
                  sub_q <= op_L2_in & ~is_I_type_in;
                  sra_q <= op_L2_in;
                  tag_q <= rob_id_in;
                  m_q   <= is_m_in & ~is_I_type_in;
                  cnt   <= '0;
                  if (!is_m_in || is_I_type_in) begin
                     pend <= 1'b1;
                  end else if (!op_L1_in[2]) begin
                     state <= S_MUL;
                  end else if (in_special) begin
                     pend <= 1'b1;
                  end else begin
                     state  <= S_DIV;
                     a_q    <= mag1;
                     b_q    <= mag2;
                     rem_q  <= '0;
                     dneg_q <= in_signed & (opr1_in[XLEN-1] ^ opr2_in[XLEN-1]);
                     rneg_q <= in_signed & opr1_in[XLEN-1];
                  end
               end
            end
            S_MUL: begin
               if (cnt == MUL_LAST) begin
                  value_out  <= mul_res;
                  rob_id_out <= tag_q;
                  ready_out  <= 1'b1;
                  state      <= S_IDLE;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DIV: begin
               if (cnt == DIV_LAST) begin
                  value_out  <= div_res;
                  rob_id_out <= tag_q;
                  ready_out  <= 1'b1;
                  state      <= S_IDLE;
                  cnt        <= '0;
               end else begin
                  a_q   <= quo_nxt;
                  rem_q <= rem_nxt;
                  cnt   <= cnt + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_m_unit.sv
// Bench for alu_m_unit: directed scenarios plus random ops against an arithmetic reference model.
// Latency: each op is waited on with a bounded cycle budget and its arrival cycle is compared.
// Backpressure: exercises busy-time issue, rdy_in freeze, flush and reset mid-operation.
module tb_alu_m_unit;
   localparam int XLEN = 32;
   localparam int TW   = 5;
   localparam int ML   = 2;
   localparam logic [31:0] SMIN = 32'h8000_0000;

   logic          clk = 1'b0;
   logic          rst_n, rdy, flush, valid;
   logic [31:0]   opr1, opr2;
   logic [TW-1:0] tag;
   logic [2:0]    f3;
   logic          l2, is_m, is_i;
   logic          busy, ready;
   logic [31:0]   value;
   logic [TW-1:0] rob_id;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_m_unit #(.XLEN(XLEN), .TAG_WIDTH(TW), .MUL_LATENCY(ML)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .need_flush_in(flush),
      .valid_in(valid), .opr1_in(opr1), .opr2_in(opr2), .rob_id_in(tag),
      .op_L1_in(f3), .op_L2_in(l2), .is_m_in(is_m), .is_I_type_in(is_i),
      .busy_out(busy), .value_out(value), .rob_id_out(rob_id), .ready_out(ready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
      end
   endtask

   // Reference result computed with 64-bit integer arithmetic
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic sel, input logic m, input logic imm);
      longint sa, sb;
      longint unsigned ua, ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      r  = '0;
      if (imm || !m) begin
         case (op)
            3'd0: r = (sel && !imm) ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = sel ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end else begin
         case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ((a == SMIN && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd6: r = (b == 0) ? a : ((a == SMIN && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb));
            default: r = (b == 0) ? a : 32'(ua % ub);
         endcase
      end
      return r;
   endfunction

   function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op, input logic m, input logic imm);
      if (imm || !m) return 1;
      if (!op[2]) return ML;
      if (b == 0 || (!op[0] && a == SMIN && b == 32'hFFFF_FFFF)) return 1;
      return XLEN + 1;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 4))
         0: return 32'h0;
         1: return SMIN;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom();
      endcase
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic sel, input logic m, input logic imm, input logic [TW-1:0] t);
      opr1 = a; opr2 = b; f3 = op; l2 = sel; is_m = m; is_i = imm; tag = t; valid = 1'b1;
   endtask

   // Issue one op, wait for its pulse, compare latency, busy, value and tag
   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic sel, input logic m, input logic imm, input logic [TW-1:0] t);
      logic [31:0] ev;
      int elat, n;
      ev   = model(a, b, op, sel, m, imm);
      elat = exp_lat(a, b, op, m, imm);
      drive(a, b, op, sel, m, imm, t);
      step();
      valid = 1'b0;
      check({name, "_busy"}, 32'(busy), (elat > 1) ? 32'd1 : 32'd0);
      n = 0;
      do begin
         step();
         n++;
      end while (!ready && n < 100);
      check({name, "_lat"}, 32'(n), 32'(elat));
      check({name, "_val"}, value, ev);
      check({name, "_tag"}, 32'(rob_id), 32'(t));
   endtask

   initial begin
      int n;
      logic saw;
      rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
      drive(32'd1, 32'd2, 3'd0, 1'b0, 1'b0, 1'b0, 5'd9);
      step();
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_value", value, 32'd0);
      check("rst_tag", 32'(rob_id), 32'd0);
      valid = 1'b0;
      rst_n = 1'b1;
      step();
      check("rst_no_result", 32'(ready), 32'd0);

      // back-to-back ADD then SUB
      drive(32'd7, 32'd5, 3'd0, 1'b0, 1'b0, 1'b0, 5'd3);
      step();
      check("b2b_busy0", 32'(busy), 32'd0);
      drive(32'd5, 32'd7, 3'd0, 1'b1, 1'b0, 1'b0, 5'd4);
      step();
      valid = 1'b0;
      check("add_ready", 32'(ready), 32'd1);
      check("add_val", value, 32'd12);
      check("add_tag", 32'(rob_id), 32'd3);
      check("b2b_busy1", 32'(busy), 32'd0);
      step();
      check("sub_ready", 32'(ready), 32'd1);
      check("sub_val", value, 32'hFFFF_FFFE);
      check("sub_tag", 32'(rob_id), 32'd4);
      step();
      check("sub_pulse_end", 32'(ready), 32'd0);

      run_op("sra", SMIN, 32'h24, 3'd5, 1'b1, 1'b0, 1'b0, 5'd5);
      run_op("slt", 32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0, 1'b0, 1'b0, 5'd6);
      run_op("sltu", 32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0, 1'b0, 1'b0, 5'd7);
      run_op("addi_l2", 32'd10, 32'd3, 3'd0, 1'b1, 1'b1, 1'b1, 5'd8);
      run_op("mulh", SMIN, SMIN, 3'd1, 1'b0, 1'b1, 1'b0, 5'd10);

      // MULHU with an ignored issue attempt while busy
      drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 1'b0, 1'b1, 1'b0, 5'd11);
      step();
      drive(32'd1, 32'd1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd12);
      step();
      valid = 1'b0;
      check("mulhu_busy", 32'(busy), 32'd1);
      step();
      check("mulhu_ready", 32'(ready), 32'd1);
      check("mulhu_val", value, 32'hFFFF_FFFE);
      check("mulhu_tag", 32'(rob_id), 32'd11);
      step();
      check("ignored_issue0", 32'(ready), 32'd0);
      step();
      check("ignored_issue1", 32'(ready), 32'd0);

      run_op("div", 32'hFFFF_FFF9, 32'd2, 3'd4, 1'b0, 1'b1, 1'b0, 5'd13);
      run_op("rem", 32'hFFFF_FFF9, 32'd2, 3'd6, 1'b0, 1'b1, 1'b0, 5'd14);

      // divide frozen for 5 cycles by rdy_in
      drive(32'hFFFF_FFF9, 32'd2, 3'd4, 1'b0, 1'b1, 1'b0, 5'd15);
      step();
      valid = 1'b0;
      n = 0;
      repeat (10) begin step(); n++; end
      rdy = 1'b0;
      repeat (5) begin step(); n++; end
      check("freeze_busy", 32'(busy), 32'd1);
      rdy = 1'b1;
      do begin
         step();
         n++;
      end while (!ready && n < 100);
      check("freeze_lat", 32'(n), 32'd38);
      check("freeze_val", value, 32'hFFFF_FFFD);

      run_op("divu_zero", 32'd1234, 32'd0, 3'd5, 1'b0, 1'b1, 1'b0, 5'd16);
      run_op("rem_ovf", SMIN, 32'hFFFF_FFFF, 3'd6, 1'b0, 1'b1, 1'b0, 5'd17);
      run_op("div_ovf", SMIN, 32'hFFFF_FFFF, 3'd4, 1'b0, 1'b1, 1'b0, 5'd18);
      run_op("rem_zero", 32'd77, 32'd0, 3'd6, 1'b0, 1'b1, 1'b0, 5'd19);

      // reset in the middle of a multiply
      drive(32'd3, 32'd5, 3'd0, 1'b0, 1'b1, 1'b0, 5'd20);
      step();
      valid = 1'b0;
      rst_n = 1'b0;
      step();
      check("midrst_value", value, 32'd0);
      check("midrst_tag", 32'(rob_id), 32'd0);
      check("midrst_ready", 32'(ready), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      step();

      // flush at cycle 10 of a divide
      drive(32'd100, 32'd7, 3'd4, 1'b0, 1'b1, 1'b0, 5'd21);
      step();
      valid = 1'b0;
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_ready", 32'(ready), 32'd0);
      saw = 1'b0;
      repeat (40) begin step(); if (ready) saw = 1'b1; end
      check("flush_no_result", 32'(saw), 32'd0);

      // ADD issued together with flush is dropped
      drive(32'd2, 32'd2, 3'd0, 1'b0, 1'b0, 1'b0, 5'd22);
      flush = 1'b1;
      step();
      valid = 1'b0;
      flush = 1'b0;
      saw = 1'b0;
      repeat (3) begin step(); if (ready) saw = 1'b1; end
      check("flush_issue_dropped", 32'(saw), 32'd0);

      for (int k = 0; k < 40; k++) begin
         run_op($sformatf("rnd%0d", k), pick(), pick(), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
